// File: rtl/key_pulse_gen.sv
// Four-button front end: synchronise, debounce, and turn presses into one-hot key pulses
// with auto-repeat on the most recently pressed button.
module key_pulse_gen #(
    parameter int unsigned DEBOUNCE     = 500000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] btn_n,
    input  logic       en,
    output logic [3:0] keys,
    output logic [3:0] held
);

    localparam int unsigned DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    stable_q, stable_d;
    logic [DW-1:0] db_cnt_q [4];
    logic [DW-1:0] db_cnt_d [4];
    logic [3:0]    held_q, held_prev_q;
    logic [3:0]    press, new_press;
    logic [1:0]    pick_idx;

    state_e        state_q, state_d;
    logic [1:0]    lock_q, lock_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          fire;
    logic [3:0]    keys_q, keys_d;

    // Stable values are in the raw active-low sense; held is their registered inverse.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            stable_q    <= 4'hF;
            held_q      <= 4'h0;
            held_prev_q <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= btn_n;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            held_q      <= ~stable_q;
            held_prev_q <= held_q;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign press = held_q & ~held_prev_q;

    // While repeating, only presses of other keys may preempt the locked one.
    assign new_press = (state_q == StIdle) ? press : (press & ~(4'b0001 << lock_q));

    always_comb begin
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (new_press[i]) begin
                pick_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            lock_q  <= 2'd0;
            rcnt_q  <= '0;
            keys_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rcnt_q  <= rcnt_d;
            keys_q  <= keys_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rcnt_d  = rcnt_q;
        fire    = 1'b0;
        if (!en) begin
            state_d = StIdle;
            rcnt_d  = '0;
        end else if (|new_press) begin
            fire    = 1'b1;
            lock_d  = pick_idx;
            rcnt_d  = '0;
            state_d = StDelay;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StDelay: begin
                    if (!held_q[lock_q]) begin
                        state_d = StIdle;
                    end else if (rcnt_q == RD_LAST) begin
                        fire    = 1'b1;
                        rcnt_d  = '0;
                        state_d = StRepeat;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (!held_q[lock_q]) begin
                        state_d = StIdle;
                    end else if (rcnt_q == RR_LAST) begin
                        fire   = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        keys_d = 4'h0;
        if (fire) begin
            keys_d = 4'b0001 << lock_d;
        end
    end

    assign keys = keys_q;
    assign held = held_q;

endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE, default 500000, is the number of consecutive cycles a synchronized button must differ from its stable value before that value updates (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the cycles from the first pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 5000000, is the cycles between successive auto-repeat pulses.
REQ-004 clock  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 btn_n  input  4  raw active-low push buttons: bit0 up, bit1 down, bit2 left, bit3 right; asynchronous to clock.
REQ-007 en  input  1  pulse enable; 0 suppresses all keys pulses.
REQ-008 keys  output  4  one-hot single-cycle key pulse, bit order as btn_n; drives the cursor/level key input directly.
REQ-009 held  output  4  debounced active-high pressed level per button.

Function
REQ-010 Each btn_n bit SHALL pass through a 2-flop synchronizer whose flops reset to 1 (released).
REQ-011 Each bit SHALL have its own debounce counter: count while synchronized value != stable value, clear when equal; stable value toggles and counter clears when count reaches DEBOUNCE-1.
REQ-012 held[i] SHALL be the inverted stable value, registered; bounces shorter than DEBOUNCE cycles SHALL never change held.
REQ-013 A press event on bit i SHALL be held[i] 0->1 between consecutive cycles, detected against a registered copy of held.
REQ-014 keys SHALL be registered, contain at most one set bit in any cycle, and be high for exactly one cycle per pulse.
REQ-015 FSM states: IDLE, DELAY, REPEAT; a lock register holds the 2-bit index of the key being repeated; one shared repeat counter sized for max(REPEAT_DELAY, REPEAT_RATE).
REQ-016 IDLE: on any press event with en=1, pulse the highest-priority newly pressed key (up > down > left > right) in the following cycle, lock it, clear counter, go DELAY.
REQ-017 DELAY: when counter reaches REPEAT_DELAY-1, pulse locked key, clear counter, go REPEAT; otherwise increment.
REQ-018 REPEAT: when counter reaches REPEAT_RATE-1, pulse locked key and clear counter; otherwise increment.
REQ-019 In DELAY or REPEAT, if held of the locked key is 0, go IDLE with no pulse, even if other keys remain held.
REQ-020 In DELAY or REPEAT, a press event on a key other than the locked one SHALL pulse that key (priority per REQ-016), relock it, clear counter, go DELAY; this takes precedence over a same-cycle repeat pulse.
REQ-021 Release of the locked key in the same cycle as a new press event SHALL follow REQ-020.
REQ-022 en=0 SHALL force keys=0 and FSM to IDLE next cycle; held keeps updating; keys already held when en rises SHALL NOT pulse until re-pressed.
REQ-023 Pulse latency SHALL be exactly one cycle after held[i] rises; total from btn_n edge is 2 + DEBOUNCE + 2 cycles.

Reset
REQ-024 While reset_n=0: synchronizer flops and stable values = 1, held=0, keys=0, counters=0, lock=0, FSM=IDLE, effective immediately without a clock edge.
REQ-025 A button held low through reset release SHALL debounce normally and produce one press pulse.

Verification (DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_RATE=5)
REQ-026 btn_n[0] low for 3 cycles then high -> held=0000, keys never nonzero.
REQ-027 btn_n[1] low 60 cycles, en=1 -> held[1] rises; keys=0010 one cycle later; next pulses 10, 15, 20 cycles after the first; none after held[1] falls.
REQ-028 btn_n[0] and btn_n[3] low in the same cycle -> single keys=0001; repeats only 0001; release bit0 with bit3 still low -> IDLE, no 1000 pulse.
REQ-029 Hold up; 4 cycles after its first pulse press down -> 0010 pulse one cycle after held[1] rises; next pulse 0010 after 10 cycles; no further 0001.
REQ-030 reset_n low for 1 cycle mid-REPEAT with btn_n[2] held low -> keys=0, held=0 asynchronously; after release, one 0100 pulse after 2+4+2 cycles, then repeats.
REQ-031 en=0 with btn_n[3] held 40 cycles -> held[3]=1, keys=0 throughout; en raised while still held -> no pulse.
